// File: rtl/uart_tx_fifo.sv
// CPU-bus-facing byte FIFO that feeds a UART transmitter, with a DATA and a STATUS register.
// Define UART_TX_FIFO_BLOCKING_EN to stall DATA writes on a full FIFO instead of dropping them.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_valid,
    input  logic        bus_addr,
    input  logic [3:0]  bus_wstrb,
    input  logic [31:0] bus_wdata,
    output logic        bus_ready,
    output logic [31:0] bus_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_next;
    logic [LW-1:0] level;
    logic [LW-1:0] level_next;
    logic          overflow;
    logic          overflow_next;
    logic          req;
    logic          is_read;
    logic          push_req;
    logic          full;
    logic          pop;
    logic          accept;
    logic          push;
    logic          ovf_set;
    logic          ovf_clr;
    logic [7:0]    head_next;
    logic [31:0]   status_word;
    logic [31:0]   rdata_next;
    logic          unused_wdata;

    assign unused_wdata = ^{bus_wdata[31:8], bus_wdata[1:0]};

    // Request decode, FIFO bookkeeping and next head-of-queue byte
    always_comb begin
        req      = bus_valid & ~bus_ready;
        is_read  = (bus_wstrb == 4'd0);
        push_req = ~bus_addr & bus_wstrb[0];
        full     = (level == FULL_LEVEL);
        pop      = tx_data_valid & tx_data_ready;
`ifdef UART_TX_FIFO_BLOCKING_EN
        accept   = req & ~(push_req & full & ~pop);
        push     = accept & push_req;
        ovf_set  = 1'b0;
`else
        accept   = req;
        push     = accept & push_req & (~full | pop);
        ovf_set  = accept & push_req & full & ~pop;
`endif
        ovf_clr  = accept & bus_addr & bus_wstrb[0] & bus_wdata[2];

        level_next    = level + LW'(push) - LW'(pop);
        wr_ptr_next   = push ? wr_ptr + AW'(1) : wr_ptr;
        rd_ptr_next   = pop ? rd_ptr + AW'(1) : rd_ptr;
        overflow_next = (overflow | ovf_set) & ~ovf_clr;

        // The byte being written becomes the head only when the queue is otherwise empty
        if (push && (wr_ptr == rd_ptr_next)) begin
            head_next = bus_wdata[7:0];
        end else begin
            head_next = mem[rd_ptr_next];
        end

        status_word = {16'd0, 8'(level), 5'd0, overflow, full, (level == '0)};
        rdata_next  = 32'd0;
        if (accept && is_read && bus_addr) begin
            rdata_next = status_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            overflow      <= 1'b0;
            bus_ready     <= 1'b0;
            bus_rdata     <= 32'd0;
            tx_data_valid <= 1'b0;
            tx_data       <= 8'd0;
        end else begin
            wr_ptr        <= wr_ptr_next;
            rd_ptr        <= rd_ptr_next;
            level         <= level_next;
            overflow      <= overflow_next;
            bus_ready     <= accept;
            bus_rdata     <= rdata_next;
            tx_data_valid <= (level_next != '0);
            tx_data       <= (level_next != '0) ? head_next : 8'd0;
        end
    end

    // Storage is not reset; only the pointers define which entries are live
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_wdata[7:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16); follows UART_TX_FIFO_BLOCKING_EN if defined.
module tb_uart_tx_fifo;

    logic        clk;
    logic        reset;
    logic        bus_valid;
    logic        bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ready;

    int          checks;
    int          failures;
    bit          rand_rdy;
    logic        post_ready;
    logic [31:0] post_rdata;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus_valid     (bus_valid),
        .bus_addr      (bus_addr),
        .bus_wstrb     (bus_wstrb),
        .bus_wdata     (bus_wdata),
        .bus_ready     (bus_ready),
        .bus_rdata     (bus_rdata),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every byte the transmitter actually takes
    always @(posedge clk) begin
        if (!reset && tx_data_valid && tx_data_ready) got_q.push_back(tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic addr, input logic [3:0] strb, input logic [31:0] wdata,
                        output logic [31:0] rdata, output int lat);
        bit got;
        got   = 1'b0;
        lat   = 0;
        rdata = 32'd0;
        @(negedge clk);
        if (rand_rdy) tx_data_ready = ($urandom_range(0, 3) != 0);
        bus_valid = 1'b1;
        bus_addr  = addr;
        bus_wstrb = strb;
        bus_wdata = wdata;
        for (int i = 0; i < 16 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_ready) begin
                got   = 1'b1;
                rdata = bus_rdata;
            end
        end
        bus_valid = 1'b0;
        bus_addr  = 1'b0;
        bus_wstrb = 4'd0;
        bus_wdata = 32'd0;
        if (!got) lat = -1;
        @(posedge clk);
        #1;
        post_ready = bus_ready;
        post_rdata = bus_rdata;
    endtask

    task automatic wr(input string tag, input logic addr, input logic [3:0] strb, input logic [31:0] wdata);
        logic [31:0] rd_val;
        int          lat;
        xfer(addr, strb, wdata, rd_val, lat);
        check({tag, " latency"}, 32'(lat), 32'd1);
        check({tag, " ready pulse width"}, {31'd0, post_ready}, 32'd0);
    endtask

    task automatic rd(input string tag, input logic addr, input logic [31:0] exp);
        logic [31:0] rd_val;
        int          lat;
        xfer(addr, 4'd0, 32'd0, rd_val, lat);
        check({tag, " latency"}, 32'(lat), 32'd1);
        check({tag, " rdata"}, rd_val, exp);
        check({tag, " rdata idle"}, post_rdata, 32'd0);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        tx_data_ready = 1'b1;
        while (tx_data_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        tx_data_ready = 1'b0;
        check({tag, " drain done"}, {31'd0, tx_data_valid}, 32'd0);
    endtask

    task automatic compare_q(input string tag);
        check({tag, " byte count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s byte %0d", tag, i),
                  (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD_BEEF, {24'd0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rand_rdy      = 1'b0;
        reset         = 1'b1;
        bus_valid     = 1'b0;
        bus_addr      = 1'b0;
        bus_wstrb     = 4'd0;
        bus_wdata     = 32'd0;
        tx_data_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("reset bus_ready", {31'd0, bus_ready}, 32'd0);
        check("reset bus_rdata", bus_rdata, 32'd0);
        check("reset tx_data_valid", {31'd0, tx_data_valid}, 32'd0);
        check("reset tx_data", {24'd0, tx_data}, 32'd0);
        reset = 1'b0;
        rd("status after reset", 1'b1, 32'h0000_0001);

        // Two bytes straight through
        tx_data_ready = 1'b1;
        wr("wr 0x41", 1'b0, 4'h1, 32'h41); exp_q.push_back(8'h41);
        wr("wr 0x42", 1'b0, 4'h1, 32'h42); exp_q.push_back(8'h42);
        repeat (3) @(negedge clk);
        check("pass-through valid falls", {31'd0, tx_data_valid}, 32'd0);
        tx_data_ready = 1'b0;
        compare_q("pass-through");

        // Fill to full, then drain in order
        for (int i = 0; i < 16; i++) begin
            wr("fill", 1'b0, 4'hF, 32'hFFFF_FF00 | 32'(i));
            exp_q.push_back(8'(i));
        end
        rd("status full", 1'b1, 32'h0000_1002);
        rd("data read", 1'b0, 32'h0000_0000);
        drain("fill");
        compare_q("fill order");
        rd("status drained", 1'b1, 32'h0000_0001);

        // Write to a full FIFO
        for (int i = 0; i < 16; i++) begin
            wr("refill", 1'b0, 4'h1, 32'h10 + 32'(i));
            exp_q.push_back(8'h10 + 8'(i));
        end
`ifdef UART_TX_FIFO_BLOCKING_EN
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = 1'b0; bus_wstrb = 4'h1; bus_wdata = 32'hAA;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("stall while full", {31'd0, bus_ready}, 32'd0);
        end
        @(negedge clk);
        tx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_data_ready = 1'b0;
        check("stall released by pop", {31'd0, bus_ready}, 32'd1);
        bus_valid = 1'b0; bus_wstrb = 4'd0; bus_wdata = 32'd0;
        exp_q.push_back(8'hAA);
        @(posedge clk);
        rd("status after stall", 1'b1, 32'h0000_1002);
`else
        wr("wr 0xAA when full", 1'b0, 4'h1, 32'hAA);
        rd("status overflow", 1'b1, 32'h0000_1006);
        wr("status wr no strb0", 1'b1, 4'h2, 32'h4);
        rd("status still overflow", 1'b1, 32'h0000_1006);
        wr("status clear", 1'b1, 4'h1, 32'h4);
        rd("status cleared", 1'b1, 32'h0000_1002);
`endif

        // Push into a full FIFO on the same cycle as a pop
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = 1'b0; bus_wstrb = 4'h1; bus_wdata = 32'h55;
        tx_data_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_data_ready = 1'b0;
        check("push+pop when full ready", {31'd0, bus_ready}, 32'd1);
        bus_valid = 1'b0; bus_wstrb = 4'd0; bus_wdata = 32'd0;
        exp_q.push_back(8'h55);
        @(posedge clk);
        rd("status push+pop", 1'b1, 32'h0000_1002);
        drain("push+pop");
        compare_q("push+pop order");

        // Reset mid-operation with a write pending
        for (int i = 0; i < 5; i++) wr("pre-reset", 1'b0, 4'h1, 32'h60 + 32'(i));
        check("pre-reset valid", {31'd0, tx_data_valid}, 32'd1);
        @(negedge clk);
        bus_valid = 1'b1; bus_addr = 1'b0; bus_wstrb = 4'h1; bus_wdata = 32'h99;
        #2;
        reset = 1'b1;
        #1;
        check("reset mid tx_data_valid", {31'd0, tx_data_valid}, 32'd0);
        check("reset mid bus_ready", {31'd0, bus_ready}, 32'd0);
        check("reset mid tx_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        bus_valid = 1'b0; bus_wstrb = 4'd0; bus_wdata = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        rd("status after mid reset", 1'b1, 32'h0000_0001);

        // DATA write without byte-0 strobe completes but queues nothing
        wr("data wr no strb0", 1'b0, 4'h2, 32'h77);
        rd("status no push", 1'b1, 32'h0000_0001);
        check("no stray bytes", 32'(got_q.size()), 32'd0);
        got_q.delete();

        // Long stream with random transmitter back-pressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr("stream", 1'b0, 4'h1, 32'h80 + 32'(i));
            exp_q.push_back(8'h80 + 8'(i));
        end
        rand_rdy = 1'b0;
        drain("stream");
        compare_q("stream order");
        rd("status final", 1'b1, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
